data_fifo: RTL and testbench
============================

// Module: data_fifo
// PURPOSE
//  Synchronous single-clock FIFO that buffers flits between a producer and a consumer.
//  In the spike-out path it queues spike/config flits ahead of the flit-send FSM.
//  Storage is a separate dual-port RAM with a registered read.
//  dout becomes valid one cycle after an accepted rd_en and then holds.
// PARAMETERS
//  DATA_WIDTH  59  width of din/dout and of each RAM word
//  ADDR_WIDTH  4   address bits; DEPTH = 2**ADDR_WIDTH entries (16 by default)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  wr_en        in   1           push din this cycle
//  rd_en        in   1           pop head entry this cycle
//  din          in   DATA_WIDTH  write data
//  dout         out  DATA_WIDTH  popped data, registered, valid the cycle after an accepted pop
//  almost_full  out  1           count >= DEPTH-1
//  empty        out  1           count == 0
// BEHAVIOUR
//  - State: wr_ptr and rd_ptr (ADDR_WIDTH bits each, wrap modulo DEPTH); count (ADDR_WIDTH+1 bits).
//  - Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0.
//    empty=1 and almost_full=0 immediately.
//    dout is not reset; it is undefined until the first accepted pop. RAM contents are not reset.
//  - wr_acc = wr_en & (count != DEPTH).
//    A write while full is dropped: no pointer or count change.
//  - rd_acc = rd_en & (count != 0).
//    A read while empty is ignored: dout holds its previous value.
//  - On wr_acc: mem[wr_ptr] <= din; wr_ptr++.
//  - On rd_acc: the RAM read register captures mem[rd_ptr]; rd_ptr++.
//    The value appears on dout the next cycle and holds until the next accepted pop.
//  - count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
//  - Simultaneous push and pop:
//    - when empty: only the write is accepted.
//    - when full: only the read is accepted (the write is dropped).
//    - otherwise: both are accepted.
//  - Flags are combinational from count: empty=(count==0), almost_full=(count>=DEPTH-1).
//    almost_full rises after the (DEPTH-1)th write, leaving one slot of slack for a
//    producer that reacts one cycle late.
//  - Ordering is strict first-in first-out across pointer wrap.
// STRUCTURE
//  - No shared package needed; DEPTH is a localparam derived from ADDR_WIDTH.
//  - Sub-module fifo_ram #(DATA_WIDTH, ADDR_WIDTH).
//    Ports: clk, wr_en, rd_en, wr_data, wr_addr, rd_addr, rd_data.
//    No reset port.
//    Write: on posedge with wr_en, mem[wr_addr] <= wr_data.
//    Read: on posedge with rd_en, rd_data <= mem[rd_addr]; otherwise rd_data holds.
//    Same-address read and write in one cycle returns the old word (read-first).
//    fifo_ram is also used standalone as a small config lookup RAM, so it must not
//    depend on FIFO logic.
//  - data_fifo drives fifo_ram: wr_en=wr_acc, rd_en=rd_acc, wr_addr=wr_ptr, rd_addr=rd_ptr.
//    dout = rd_data.
// TESTING
//  Use DATA_WIDTH=59, ADDR_WIDTH=4.
//  1. Reset, then idle -> empty=1, almost_full=0.
//     Assert rst_n=0 mid-stream with 5 entries stored -> empty=1 at once; later pops return
//     only data written after reset.
//  2. Push 0x1, 0x2, 0x3 on consecutive cycles, then pop 3 times
//     -> dout = 0x1, 0x2, 0x3, each one cycle after its rd_en; empty=1 after the third pop.
//  3. Push 15 words -> almost_full=1 after the 15th and empty=0.
//     Push a 16th -> accepted.
//     Push a 17th (0xDEAD) -> dropped; the 16 pops return only the first 16 words.
//  4. rd_en while empty, with dout holding 0x3 -> dout stays 0x3; count stays 0.
//     Simultaneous wr_en and rd_en while empty -> only the write is accepted; empty=0 next cycle.
//  5. Hold count at 8 while doing 40 cycles of simultaneous push and pop of an incrementing
//     pattern -> count constant, pointers wrap, pops return the exact sequence.
//  6. fifo_ram alone: write addr 5 = 0xA5.
//     Read addr 5 -> 0xA5 next cycle; rd_en=0 -> rd_data holds.
//     Read and write addr 5 in the same cycle -> old value returned.

Source files
------------

// File: rtl/data_fifo_pkg.sv
// Shared defaults for the flit FIFO: word width and address width.
package data_fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 59;
    localparam int unsigned FIFO_ADDR_WIDTH = 4;

    // Number of entries addressed by an address of the given width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a registered, read-first read port and no reset.
// Also used standalone as a config lookup RAM, so it carries no FIFO knowledge.
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 59,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Nonblocking write and read in one block: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/data_fifo.sv
// Single-clock flit FIFO: pointer/count control around fifo_ram, dout held
// from the RAM read register until the next accepted pop.
module data_fifo
    import data_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_AF   = CW'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_acc;
    logic                  rd_acc;

    // Full drops writes, empty ignores reads; this also resolves simultaneous push/pop.
    always_comb begin
        wr_acc = wr_en & (count != COUNT_FULL);
        rd_acc = rd_en & (count != CW'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Flags follow count directly so reset clears them without a clock.
    always_comb begin
        empty       = (count == CW'(0));
        almost_full = (count >= COUNT_AF);
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .rd_en   (rd_acc),
        .wr_data (din),
        .wr_addr (wr_ptr),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_data_fifo.sv
// Randomized and directed bench for data_fifo against a queue-based model,
// plus a standalone check of fifo_ram.
module tb_data_fifo;

    localparam int unsigned DW    = 59;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          almost_full;
    logic          empty;

    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_wr_addr;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout;
    logic          dout_valid = 1'b0;

    always #5 clk = ~clk;

    data_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .din         (din),
        .dout        (dout),
        .almost_full (almost_full),
        .empty       (empty)
    );

    fifo_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .rd_en   (ram_rd_en),
        .wr_data (ram_wr_data),
        .wr_addr (ram_wr_addr),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable against the model.
    task automatic check_state(input string tag);
        check({tag, ".empty"}, 64'(empty), 64'(model_q.size() == 0));
        check({tag, ".af"}, 64'(almost_full), 64'(model_q.size() >= DEPTH - 1));
        check({tag, ".count"}, 64'(dut.count), 64'(model_q.size()));
        if (dout_valid) begin
            check({tag, ".dout"}, 64'(dout), 64'(exp_dout));
        end
    endtask

    // One clock: apply inputs, advance the queue model at the edge, then compare.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d, input string tag);
        bit w_ok;
        bit r_ok;
        wr_en = we;
        rd_en = re;
        din   = d;
        w_ok  = we && (model_q.size() != DEPTH);
        r_ok  = re && (model_q.size() != 0);
        @(posedge clk);
        if (r_ok) begin
            exp_dout   = model_q.pop_front();
            dout_valid = 1'b1;
        end
        if (w_ok) begin
            model_q.push_back(d);
        end
        #1;
        check_state(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic rand_word(output logic [DW-1:0] w);
        w = {27'($urandom), $urandom};
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] pat;

        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;
        ram_wr_data = '0;
        ram_wr_addr = '0;
        ram_rd_addr = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, '0, "idle0");
        cycle(1'b0, 1'b0, '0, "idle1");

        // Three pushes then three pops
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, DW'(i), "push3");
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, '0, "pop3");
            check("pop3.seq", 64'(dout), 64'(i));
        end
        check("pop3.empty", 64'(empty), 64'(1));

        // Pop while empty: dout holds 0x3
        cycle(1'b0, 1'b1, '0, "pop_empty");
        check("pop_empty.hold", 64'(dout), 64'h3);

        // Simultaneous push and pop on empty: only the write lands
        cycle(1'b1, 1'b1, DW'(64'h77), "both_empty");
        check("both_empty.nonempty", 64'(empty), 64'(0));
        check("both_empty.hold", 64'(dout), 64'h3);
        cycle(1'b0, 1'b1, '0, "drain1");
        check("drain1.val", 64'(dout), 64'h77);

        // Fill to full, then a dropped 17th write
        for (int i = 0; i < 15; i++) begin
            rand_word(w);
            cycle(1'b1, 1'b0, w, "fill");
        end
        check("fill15.af", 64'(almost_full), 64'(1));
        check("fill15.empty", 64'(empty), 64'(0));
        rand_word(w);
        cycle(1'b1, 1'b0, w, "fill16");
        check("fill16.count", 64'(dut.count), 64'(16));
        cycle(1'b1, 1'b0, DW'(64'hDEAD), "drop17");
        check("drop17.count", 64'(dut.count), 64'(16));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, "drain16");
        check("drain16.empty", 64'(empty), 64'(1));
        check("drain16.notdead", 64'(dout == DW'(64'hDEAD)), 64'(0));

        // Steady state at count 8 with simultaneous push/pop across wraps
        pat = DW'(64'h100);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, pat, "pre8");
            pat = pat + DW'(1);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, pat, "steady");
            check("steady.count8", 64'(dut.count), 64'(8));
            check("steady.seq", 64'(dout), 64'(DW'(64'h100) + DW'(i)));
            pat = pat + DW'(1);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "post8");

        // Mid-stream reset with five entries stored
        for (int i = 0; i < 5; i++) begin
            rand_word(w);
            cycle(1'b1, 1'b0, w, "prerst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, DW'(64'hABC), "postrst_w0");
        cycle(1'b1, 1'b0, DW'(64'hABD), "postrst_w1");
        cycle(1'b0, 1'b1, '0, "postrst_r0");
        check("postrst.first", 64'(dout), 64'hABC);
        cycle(1'b0, 1'b1, '0, "postrst_r1");
        check("postrst.second", 64'(dout), 64'hABD);
        cycle(1'b0, 1'b1, '0, "postrst_r2");

        // Random traffic, biased toward alternately filling and draining
        for (int i = 0; i < 400; i++) begin
            bit fill_phase;
            fill_phase = ((i / 50) % 2) == 0;
            rand_word(w);
            cycle($urandom_range(0, 99) < (fill_phase ? 75 : 35),
                  $urandom_range(0, 99) < (fill_phase ? 35 : 75), w, "rand");
        end

        // Standalone RAM: write, read, hold, read-first collision
        @(negedge clk);
        ram_wr_en = 1'b1; ram_wr_addr = AW'(5); ram_wr_data = DW'(64'hA5);
        @(negedge clk);
        ram_wr_en = 1'b0; ram_rd_en = 1'b1; ram_rd_addr = AW'(5);
        @(negedge clk);
        check("ram.read5", 64'(ram_rd_data), 64'hA5);
        ram_rd_en = 1'b0; ram_rd_addr = AW'(0);
        @(negedge clk);
        check("ram.hold", 64'(ram_rd_data), 64'hA5);
        ram_wr_en = 1'b1; ram_wr_data = DW'(64'h5A);
        ram_rd_en = 1'b1; ram_rd_addr = AW'(5);
        @(negedge clk);
        check("ram.readfirst", 64'(ram_rd_data), 64'hA5);
        ram_wr_en = 1'b0;
        @(negedge clk);
        check("ram.newval", 64'(ram_rd_data), 64'h5A);
        ram_rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
